// File: rtl/bit_deserializer.sv
// Serial-to-parallel word assembler with a 2-entry output FIFO and sticky
// overflow / framing error flags.
module bit_deserializer #(
  parameter int unsigned BITWIDTH  = 8,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic                fast_clk,
  input  logic                rst,
  input  logic                ser_valid,
  input  logic                ser_bit,
  input  logic                ser_first,
  output logic [BITWIDTH-1:0] par_data,
  output logic                par_valid,
  input  logic                par_ready,
  output logic [1:0]          fill,
  output logic                overflow,
  output logic                frame_err,
  input  logic                clr_err
);

  localparam int unsigned CW = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(BITWIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BITWIDTH-1:0] sh_q, sh_d;
  logic [BITWIDTH-1:0] head_q, head_d;
  logic [BITWIDTH-1:0] tail_q, tail_d;
  logic [1:0]          fill_q, fill_d;
  logic                par_valid_q, par_valid_d;
  logic                overflow_q, overflow_d;
  logic                frame_err_q, frame_err_d;

  logic                push_c;
  logic                pop_c;
  logic                ovf_set_c;
  logic                frame_set_c;
  logic [BITWIDTH-1:0] word_c;
  logic [BITWIDTH-1:0] ins_c;

  // One-hot mask of the physical par_data position for serial bit index pos
  function automatic logic [BITWIDTH-1:0] bit_mask(input logic [CW-1:0] pos);
    int unsigned phys;
    phys = (MSB_FIRST != 0) ? (BITWIDTH - 32'd1 - 32'(pos)) : 32'(pos);
    return BITWIDTH'(1) << phys;
  endfunction

  // Framing FSM: bit counter and shift register, produces a push on word completion
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    push_c      = 1'b0;
    frame_set_c = 1'b0;
    word_c      = '0;
    ins_c       = {BITWIDTH{ser_bit}} & bit_mask(cnt_q);
    if (ser_valid) begin
      unique case (state_q)
        IDLE: begin
          if (ser_first) begin
            sh_d    = {BITWIDTH{ser_bit}} & bit_mask('0);
            cnt_d   = CW'(1);
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (ser_first) begin
            frame_set_c = 1'b1;
            sh_d        = {BITWIDTH{ser_bit}} & bit_mask('0);
            cnt_d       = CW'(1);
          end else if (cnt_q == LAST_IDX) begin
            push_c  = 1'b1;
            word_c  = sh_q | ins_c;
            sh_d    = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            sh_d  = sh_q | ins_c;
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Two-entry FIFO update; empty slots are kept at zero so par_data reads 0 when empty
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    fill_d    = fill_q;
    ovf_set_c = 1'b0;
    pop_c     = par_valid_q & par_ready;
    unique case ({push_c, pop_c})
      2'b10: begin
        if (fill_q == 2'd0) begin
          head_d = word_c;
          fill_d = 2'd1;
        end else if (fill_q == 2'd1) begin
          tail_d = word_c;
          fill_d = 2'd2;
        end else begin
          ovf_set_c = 1'b1;
        end
      end
      2'b01: begin
        head_d = tail_q;
        tail_d = '0;
        fill_d = fill_q - 2'd1;
      end
      2'b11: begin
        if (fill_q == 2'd2) begin
          head_d = tail_q;
          tail_d = word_c;
        end else begin
          head_d = word_c;
        end
      end
      default: ;
    endcase
    par_valid_d = (fill_d != 2'd0);
    overflow_d  = (overflow_q & ~clr_err) | ovf_set_c;
    frame_err_d = (frame_err_q & ~clr_err) | frame_set_c;
  end

  // State registers
  always_ff @(posedge fast_clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      fill_q      <= 2'd0;
      par_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      fill_q      <= fill_d;
      par_valid_q <= par_valid_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign par_data  = head_q;
  assign par_valid = par_valid_q;
  assign fill      = fill_q;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_bit_deserializer.sv
// Directed bench for bit_deserializer: MSB-first instance plus an LSB-first
// instance sharing the same stimulus.
module tb_bit_deserializer;

  logic       fast_clk = 1'b0;
  logic       rst = 1'b0;
  logic       ser_valid = 1'b0;
  logic       ser_bit = 1'b0;
  logic       ser_first = 1'b0;
  logic       par_ready = 1'b0;
  logic       clr_err = 1'b0;

  logic [7:0] a_data, b_data;
  logic       a_valid, b_valid;
  logic [1:0] a_fill, b_fill;
  logic       a_ovf, b_ovf;
  logic       a_ferr, b_ferr;

  int errs = 0;
  int checks = 0;

  always #5 fast_clk = ~fast_clk;

  bit_deserializer #(.BITWIDTH(8), .MSB_FIRST(1)) dut_msb (
    .fast_clk(fast_clk), .rst(rst), .ser_valid(ser_valid), .ser_bit(ser_bit),
    .ser_first(ser_first), .par_data(a_data), .par_valid(a_valid),
    .par_ready(par_ready), .fill(a_fill), .overflow(a_ovf),
    .frame_err(a_ferr), .clr_err(clr_err)
  );

  bit_deserializer #(.BITWIDTH(8), .MSB_FIRST(0)) dut_lsb (
    .fast_clk(fast_clk), .rst(rst), .ser_valid(ser_valid), .ser_bit(ser_bit),
    .ser_first(ser_first), .par_data(b_data), .par_valid(b_valid),
    .par_ready(par_ready), .fill(b_fill), .overflow(b_ovf),
    .frame_err(b_ferr), .clr_err(clr_err)
  );

  // Drive one valid serial bit at the next falling edge
  task automatic send_raw(input logic b, input logic f);
    @(negedge fast_clk);
    ser_valid = 1'b1;
    ser_bit   = b;
    ser_first = f;
  endtask

  // Idle the serial input for n cycles
  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge fast_clk);
      ser_valid = 1'b0;
      ser_first = 1'b0;
      ser_bit   = 1'b0;
    end
  endtask

  // Send the first n bits of w (w[7] first) framed by ser_first, with optional
  // random gaps; returns one cycle after the last bit is sampled
  task automatic send_bits(input logic [7:0] w, input int n, input int gapmax,
                           input logic rdy_last);
    for (int i = 0; i < n; i++) begin
      if (gapmax > 0) idle_cycles(int'($urandom_range(gapmax, 0)));
      send_raw(w[7-i], (i == 0));
      if (rdy_last && (i == n - 1)) par_ready = 1'b1;
    end
    idle_cycles(1);
  endtask

  task automatic do_reset();
    @(negedge fast_clk);
    rst = 1'b0;
    @(negedge fast_clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge fast_clk);
    checks++; if (a_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", a_valid); end
    checks++; if (a_data !== 8'h00) begin errs++; $display("FAIL reset_data: got %h want 00", a_data); end
    checks++; if (a_fill !== 2'd0) begin errs++; $display("FAIL reset_fill: got %0d want 0", a_fill); end
    checks++; if (a_ovf !== 1'b0) begin errs++; $display("FAIL reset_ovf: got %b want 0", a_ovf); end
    checks++; if (a_ferr !== 1'b0) begin errs++; $display("FAIL reset_ferr: got %b want 0", a_ferr); end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    par_ready = 1'b1;
    send_bits(8'hA5, 8, 0, 1'b0);
    checks++; if (a_valid !== 1'b1) begin errs++; $display("FAIL basic_valid: got %b want 1", a_valid); end
    checks++; if (a_data !== 8'hA5) begin errs++; $display("FAIL basic_data: got %h want a5", a_data); end
    checks++; if (a_fill !== 2'd1) begin errs++; $display("FAIL basic_fill: got %0d want 1", a_fill); end
    idle_cycles(1);
    checks++; if (a_fill !== 2'd0) begin errs++; $display("FAIL basic_drain_fill: got %0d want 0", a_fill); end
    checks++; if (a_valid !== 1'b0) begin errs++; $display("FAIL basic_drain_valid: got %b want 0", a_valid); end
    checks++; if (a_data !== 8'h00) begin errs++; $display("FAIL basic_empty_data: got %h want 00", a_data); end
  endtask

  task automatic test_gaps();
    par_ready = 1'b1;
    send_raw(1'b1, 1'b0);
    send_raw(1'b1, 1'b0);
    idle_cycles(1);
    checks++; if (a_valid !== 1'b0) begin errs++; $display("FAIL idle_discard: got %b want 0", a_valid); end
    send_bits(8'h3C, 8, 3, 1'b0);
    checks++; if (a_valid !== 1'b1 || a_data !== 8'h3C) begin errs++; $display("FAIL gap_word0: got %b/%h want 1/3c", a_valid, a_data); end
    send_bits(8'hC3, 8, 3, 1'b0);
    checks++; if (a_valid !== 1'b1 || a_data !== 8'hC3) begin errs++; $display("FAIL gap_word1: got %b/%h want 1/c3", a_valid, a_data); end
    idle_cycles(1);
    checks++; if (a_ovf !== 1'b0 || a_ferr !== 1'b0) begin errs++; $display("FAIL gap_flags: got %b/%b want 0/0", a_ovf, a_ferr); end
  endtask

  task automatic test_overflow();
    par_ready = 1'b0;
    send_bits(8'h01, 8, 0, 1'b0);
    checks++; if (a_fill !== 2'd1) begin errs++; $display("FAIL ovf_fill1: got %0d want 1", a_fill); end
    send_bits(8'h02, 8, 0, 1'b0);
    checks++; if (a_fill !== 2'd2 || a_data !== 8'h01) begin errs++; $display("FAIL ovf_fill2: got %0d/%h want 2/01", a_fill, a_data); end
    send_bits(8'h03, 8, 0, 1'b0);
    checks++; if (a_fill !== 2'd2 || a_ovf !== 1'b1) begin errs++; $display("FAIL ovf_set: got fill %0d ovf %b want 2/1", a_fill, a_ovf); end
    checks++; if (a_data !== 8'h01) begin errs++; $display("FAIL ovf_head_stable: got %h want 01", a_data); end
    par_ready = 1'b1;
    idle_cycles(1);
    checks++; if (a_data !== 8'h02 || a_fill !== 2'd1) begin errs++; $display("FAIL ovf_pop1: got %h/%0d want 02/1", a_data, a_fill); end
    idle_cycles(1);
    checks++; if (a_valid !== 1'b0 || a_fill !== 2'd0) begin errs++; $display("FAIL ovf_pop2: got %b/%0d want 0/0", a_valid, a_fill); end
    checks++; if (a_ovf !== 1'b1) begin errs++; $display("FAIL ovf_sticky: got %b want 1", a_ovf); end
    clr_err = 1'b1;
    idle_cycles(1);
    clr_err = 1'b0;
    checks++; if (a_ovf !== 1'b0) begin errs++; $display("FAIL ovf_clear: got %b want 0", a_ovf); end
  endtask

  task automatic test_back_to_back();
    par_ready = 1'b0;
    send_bits(8'h11, 8, 0, 1'b0);
    send_bits(8'h22, 8, 0, 1'b0);
    send_bits(8'h33, 8, 0, 1'b1);
    checks++; if (a_fill !== 2'd2 || a_data !== 8'h22) begin errs++; $display("FAIL b2b_full_pushpop: got %0d/%h want 2/22", a_fill, a_data); end
    checks++; if (a_ovf !== 1'b0) begin errs++; $display("FAIL b2b_no_ovf: got %b want 0", a_ovf); end
    idle_cycles(1);
    par_ready = 1'b0;
    checks++; if (a_fill !== 2'd1 || a_data !== 8'h33) begin errs++; $display("FAIL b2b_pop: got %0d/%h want 1/33", a_fill, a_data); end
    send_bits(8'h44, 8, 0, 1'b1);
    checks++; if (a_fill !== 2'd1 || a_data !== 8'h44) begin errs++; $display("FAIL b2b_one_pushpop: got %0d/%h want 1/44", a_fill, a_data); end
    idle_cycles(1);
    checks++; if (a_fill !== 2'd0) begin errs++; $display("FAIL b2b_drain: got %0d want 0", a_fill); end
  endtask

  task automatic test_frame();
    par_ready = 1'b1;
    send_bits(8'hFF, 5, 0, 1'b0);
    checks++; if (a_valid !== 1'b0 || a_ferr !== 1'b0) begin errs++; $display("FAIL frame_partial: got %b/%b want 0/0", a_valid, a_ferr); end
    send_bits(8'h5A, 8, 0, 1'b0);
    checks++; if (a_ferr !== 1'b1) begin errs++; $display("FAIL frame_err_set: got %b want 1", a_ferr); end
    checks++; if (a_data !== 8'h5A || a_fill !== 2'd1) begin errs++; $display("FAIL frame_word: got %h/%0d want 5a/1", a_data, a_fill); end
    idle_cycles(1);
    checks++; if (a_fill !== 2'd0) begin errs++; $display("FAIL frame_only_one: got %0d want 0", a_fill); end
    send_bits(8'hFF, 3, 0, 1'b0);
    send_raw(1'b1, 1'b1);
    clr_err = 1'b1;
    idle_cycles(1);
    clr_err = 1'b0;
    checks++; if (a_ferr !== 1'b1) begin errs++; $display("FAIL frame_set_wins: got %b want 1", a_ferr); end
    for (int i = 0; i < 7; i++) send_raw((i == 6), 1'b0);
    idle_cycles(1);
    checks++; if (a_valid !== 1'b1 || a_data !== 8'h81) begin errs++; $display("FAIL frame_restart_word: got %b/%h want 1/81", a_valid, a_data); end
    clr_err = 1'b1;
    idle_cycles(1);
    clr_err = 1'b0;
    checks++; if (a_ferr !== 1'b0) begin errs++; $display("FAIL frame_clear: got %b want 0", a_ferr); end
  endtask

  task automatic test_reset_mid();
    par_ready = 1'b0;
    send_bits(8'h11, 8, 0, 1'b0);
    for (int i = 0; i < 4; i++) send_raw(1'b1, (i == 0));
    #2;
    rst = 1'b0;
    ser_valid = 1'b0;
    ser_first = 1'b0;
    #1;
    checks++; if (a_valid !== 1'b0 || a_data !== 8'h00 || a_fill !== 2'd0) begin errs++; $display("FAIL rstmid_fifo: got %b/%h/%0d want 0/00/0", a_valid, a_data, a_fill); end
    checks++; if (a_ovf !== 1'b0 || a_ferr !== 1'b0) begin errs++; $display("FAIL rstmid_flags: got %b/%b want 0/0", a_ovf, a_ferr); end
    @(negedge fast_clk);
    rst = 1'b1;
    par_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_raw(1'b0, 1'b0);
    idle_cycles(1);
    checks++; if (a_valid !== 1'b0) begin errs++; $display("FAIL rstmid_need_first: got %b want 0", a_valid); end
    send_bits(8'hFF, 8, 0, 1'b0);
    checks++; if (a_valid !== 1'b1 || a_data !== 8'hFF) begin errs++; $display("FAIL rstmid_word: got %b/%h want 1/ff", a_valid, a_data); end
    idle_cycles(1);
  endtask

  task automatic test_bit_order();
    do_reset();
    par_ready = 1'b1;
    send_bits(8'hA5, 8, 0, 1'b0);
    checks++; if (a_data !== 8'hA5) begin errs++; $display("FAIL order_msb_a5: got %h want a5", a_data); end
    checks++; if (b_valid !== 1'b1 || b_data !== 8'hA5) begin errs++; $display("FAIL order_lsb_a5: got %b/%h want 1/a5", b_valid, b_data); end
    send_bits(8'hC0, 8, 0, 1'b0);
    checks++; if (a_data !== 8'hC0) begin errs++; $display("FAIL order_msb_c0: got %h want c0", a_data); end
    checks++; if (b_data !== 8'h03) begin errs++; $display("FAIL order_lsb_03: got %h want 03", b_data); end
    idle_cycles(1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_overflow();
    test_back_to_back();
    test_frame();
    test_reset_mid();
    test_bit_order();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/bit_deserializer.md
BIT_DESERIALIZER -- requirements
Module: bit_deserializer

Interface
REQ-001 SHALL have parameter BITWIDTH, default 8: serial word length in bits; legal range 2..32.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = first serial bit lands in par_data[BITWIDTH-1]; 0 = first bit lands in par_data[0].
REQ-003 SHALL have port fast_clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ser_valid  input  1  ser_bit is valid this cycle.
REQ-006 SHALL have port ser_bit  input  1  serial data bit.
REQ-007 SHALL have port ser_first  input  1  marks bit 0 of a word; sampled only when ser_valid=1; driven by the upstream word-framing counter's first-bit strobe.
REQ-008 SHALL have port par_data  output  BITWIDTH  assembled word at FIFO head.
REQ-009 SHALL have port par_valid  output  1  FIFO non-empty.
REQ-010 SHALL have port par_ready  input  1  consumer accepts head word.
REQ-011 SHALL have port fill  output  2  FIFO occupancy 0..2.
REQ-012 SHALL have port overflow  output  1  sticky: completed word dropped because FIFO full.
REQ-013 SHALL have port frame_err  output  1  sticky: ser_first seen mid-word.
REQ-014 SHALL have port clr_err  input  1  synchronous clear of overflow and frame_err.

Function
REQ-015 SHALL implement a two-state FSM (IDLE, SHIFT), a bit counter cnt (0..BITWIDTH-1), a shift register, and a 2-entry FIFO.
REQ-016 IDLE: ser_valid && ser_first -> store bit as bit 0, cnt=1, go SHIFT; ser_valid && !ser_first -> bit discarded, no error; !ser_valid -> stay.
REQ-017 SHIFT: ser_valid && !ser_first -> store bit at position cnt, cnt+1; !ser_valid -> hold all state (gaps of any length allowed).
REQ-018 SHIFT: ser_valid && ser_first -> set frame_err, discard partial word, store bit as new bit 0, cnt=1, stay SHIFT.
REQ-019 On the edge that samples bit BITWIDTH-1, the complete word (including that bit) SHALL be pushed into the FIFO; FSM -> IDLE, cnt=0.
REQ-020 Latency: par_valid SHALL rise the cycle after the last bit is sampled when the FIFO was empty.
REQ-021 Pop occurs on each edge with par_valid && par_ready; FIFO is in-order.
REQ-022 Push when fill=2 and no pop same edge: word dropped, overflow set, FIFO unchanged.
REQ-023 Push when fill=2 with pop same edge: push accepted, fill stays 2, no overflow.
REQ-024 Push and pop same edge at fill=1: fill stays 1, new word becomes head next cycle.
REQ-025 par_data SHALL be stable while par_valid && !par_ready; par_data SHALL be 0 when par_valid=0.
REQ-026 clr_err clears both sticky flags next edge; a set event on the same edge wins (flag stays 1).
REQ-027 fill, par_valid SHALL be registered-state derived, no combinational path from ser_* inputs.
REQ-028 par_ready SHALL be allowed to combinationally affect nothing but FIFO pop.

Reset
REQ-029 rst=0 SHALL asynchronously force: FSM IDLE, cnt=0, shift register 0, FIFO empty, par_valid=0, par_data=0, fill=0, overflow=0, frame_err=0.
REQ-030 Reset mid-word SHALL discard the partial word; first word after release requires ser_first.

Verification (BITWIDTH=8, MSB_FIRST=1 unless stated)
REQ-031 Bits 1,0,1,0,0,1,0,1 with ser_first on bit 0, par_ready=1 -> par_valid=1 one cycle after 8th bit, par_data=0xA5, fill returns 0 next cycle.
REQ-032 Words 0x3C then 0xC3 with random 0-3 cycle ser_valid gaps, par_ready=1 -> 0x3C then 0xC3 delivered, no flags.
REQ-033 par_ready=0, words 0x01,0x02,0x03 -> fill=2, overflow=1 after third; then par_ready=1 -> 0x01, 0x02 only; clr_err -> overflow=0.
REQ-034 ser_first reasserted on 6th bit of a word, followed by 0x5A framed from that bit -> frame_err=1, only 0x5A delivered.
REQ-035 rst pulsed after 4 bits of a word -> all outputs 0; next framed word 0xFF delivered correctly; MSB_FIRST=0 rerun of REQ-031 -> par_data=0xA5 bit-reversed = 0xA5.
